// File: rtl/fifo_flex.sv
// Single-clock synchronous FIFO with selectable registered / first-word-fall-through read,
// occupancy count, programmable almost flags, synchronous flush and sticky error flags.
module fifo_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
  logic                  wr_ok, rd_ok;

  assign wr_idx = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_idx = rd_ptr[ADDR_WIDTH-1:0];

  // Accept decisions look only at flags from the registered count, so a
  // simultaneous pop never frees room for a push in the same cycle (and vice versa).
  assign wr_ok = wr_en & ~full  & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & full & ~flush) overflow <= 1'b1;
      else if (clr_err)          overflow <= 1'b0;
      if (rd_en & empty & ~flush) underflow <= 1'b1;
      else if (clr_err)           underflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_idx];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     data_q <= '0;
        else if (flush) data_q <= '0;
        else if (rd_ok) data_q <= mem[rd_idx];
      end
      assign data_out = data_q;
    end
  endgenerate

  // Wrap-bit pointers and the count register must always agree.
  always_ff @(posedge clk) begin
    if (rst_n) assert (count == ADDR_WIDTH'(0) + (wr_ptr - rd_ptr));
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench: registered and FWFT instances driven in lockstep against a queue model.
module tb_fifo_flex;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n, flush, clr_err, wr_en, rd_en;
  logic [DW-1:0] data_in;

  logic [DW-1:0] dout [2];
  logic          full [2], empty [2], afull [2], aempty [2], ovf [2], udf [2];
  logic [AW:0]   cnt [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dreg;
  bit            m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .data_out(dout[0]),
    .full(full[0]), .empty(empty[0]), .almost_full(afull[0]), .almost_empty(aempty[0]),
    .count(cnt[0]), .overflow(ovf[0]), .underflow(udf[0]));

  fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .data_out(dout[1]),
    .full(full[1]), .empty(empty[1]), .almost_full(afull[1]), .almost_empty(aempty[1]),
    .count(cnt[1]), .overflow(ovf[1]), .underflow(udf[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_dreg = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endfunction

  // One clock edge of the specified behaviour, from pre-edge state.
  function automatic void model_edge(bit w, logic [DW-1:0] d, bit r, bit f, bit c);
    bit is_full  = (q.size() == DEPTH);
    bit is_empty = (q.size() == 0);
    if (w && is_full && !f) m_ovf = 1'b1;
    else if (c)             m_ovf = 1'b0;
    if (r && is_empty && !f) m_udf = 1'b1;
    else if (c)              m_udf = 1'b0;
    if (f) begin
      q.delete();
      m_dreg = '0;
    end else begin
      if (r && !is_empty) m_dreg = q.pop_front();
      if (w && !is_full)  q.push_back(d);
    end
  endfunction

  task automatic check_all();
    int n = q.size();
    logic [DW-1:0] head = '0;
    if (n > 0) head = q[0];
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("count%0d", i),  32'(cnt[i]), 32'(n));
      chk($sformatf("full%0d", i),   32'(full[i]), 32'(n == DEPTH));
      chk($sformatf("empty%0d", i),  32'(empty[i]), 32'(n == 0));
      chk($sformatf("afull%0d", i),  32'(afull[i]), 32'(n >= DEPTH - 2));
      chk($sformatf("aempty%0d", i), 32'(aempty[i]), 32'(n <= 2));
      chk($sformatf("ovf%0d", i),    32'(ovf[i]), 32'(m_ovf));
      chk($sformatf("udf%0d", i),    32'(udf[i]), 32'(m_udf));
    end
    chk("dout_reg",  32'(dout[0]), 32'(m_dreg));
    chk("dout_fwft", 32'(dout[1]), 32'(head));
  endtask

  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit f = 1'b0, input bit c = 1'b0);
    wr_en = w; data_in = d; rd_en = r; flush = f; clr_err = c;
    @(posedge clk);
    model_edge(w, d, r, f, c);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);

    // Underflow and clear, set-wins on coincident clear
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // FWFT fall-through and ack
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    // Offset pointers, then steady-state simultaneous push/pop across the wrap
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

    // Overflow set, drain to 9, flush with write
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Async reset mid-stream, then first write lands at index 0
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Randomised phases with shifting write/read bias to visit full and empty
    for (int ph = 0; ph < 12; ph++) begin
      int wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      for (int k = 0; k < 200; k++) begin
        bit w = ($urandom_range(99) < wp);
        bit r = ($urandom_range(99) < 100 - wp);
        bit f = ($urandom_range(99) < 2);
        bit c = ($urandom_range(99) < 5);
        cycle(w, 8'($urandom), r, f, c);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
